// File: rtl/inv_cipher_core.sv
// Iterative AES-128 inverse cipher: one decryption round per clock, with round keys
// fetched by index from an external, combinational key store.
module inv_cipher_core #(
    parameter int NR = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] ct_i,
    output logic [3:0]   rk_idx_o,
    input  logic [127:0] rk_i,
    input  logic         flush_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] pt_o
);

    generate
        if (NR != 10) begin : g_bad_nr
            $error("inv_cipher_core supports only NR = 10 (AES-128)");
        end
    endgenerate

    // Handshakes: a transfer happens on a rising clk_i edge where valid and ready are both
    // high; valid, once raised, holds its data stable until that edge.
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] pt_q, pt_d;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero without a special case.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte 4c+r sits in row r, column c; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    // Column mixer in its decrypt configuration (coefficients 0e 0b 0d 09).
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c    -: 8];
            a1 = s[127-32*c-8  -: 8];
            a2 = s[127-32*c-16 -: 8];
            a3 = s[127-32*c-24 -: 8];
            o[127-32*c    -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[127-32*c-8  -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[127-32*c-16 -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[127-32*c-24 -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [127:0] sub_shift;
    assign sub_shift = inv_sub_bytes(inv_shift_rows(state_q));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            state_q <= 128'h0;
            pt_q    <= 128'h0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            pt_q    <= pt_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        pt_d    = pt_q;
        if (flush_i) begin
            fsm_d = IDLE;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_d = ct_i ^ rk_i;
                        rnd_d   = 4'd9;
                        fsm_d   = ROUND;
                    end
                end
                ROUND: begin
                    state_d = inv_mix_columns(sub_shift ^ rk_i);
                    if (rnd_q == 4'd1) fsm_d = FINAL;
                    else               rnd_d = rnd_q - 4'd1;
                end
                FINAL: begin
                    pt_d  = sub_shift ^ rk_i;
                    fsm_d = DONE;
                end
                DONE: begin
                    if (out_ready_i) fsm_d = IDLE;
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rk_idx_o = 4'd10;
        case (fsm_q)
            ROUND:   rk_idx_o = rnd_q;
            FINAL:   rk_idx_o = 4'd0;
            default: rk_idx_o = 4'd10;
        endcase
    end

    // Ready is withheld while reset is asserted even though the state already reads IDLE.
    assign in_ready_o  = (fsm_q == IDLE) && rst_ni;
    assign out_valid_o = (fsm_q == DONE);
    assign pt_o        = pt_q;

endmodule

// File: tb/tb_inv_cipher_core.sv
// Bench for inv_cipher_core: a forward AES-128 model encrypts known plaintexts and the
// decrypted output must return them; key store is modelled from a software key expansion.
module tb_inv_cipher_core;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt;

    int n_vec  = 0;
    int n_fail = 0;

    logic [127:0] exp_q[$];
    logic [127:0] last_exp;
    logic [7:0]   sbox[256];
    logic [127:0] rk_tab[16];

    localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs[6];

    inv_cipher_core #(.NR(10)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .ct_i        (ct),
        .rk_idx_o    (rk_idx),
        .rk_i        (rk),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .pt_o        (pt)
    );

    assign rk = rk_tab[rk_idx];

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int r;
        int x;
        r = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x << 1;
            if (x > 255) x = x ^ 'h11b;
        end
        return r[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0]  inv;
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk_tab[r] = '0;
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] p);
        logic [7:0]   s[16];
        logic [7:0]   o[16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rk_tab[0][127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) o[4*c+q] = s[4*((c+q)%4)+q];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(o[4*c], 2) ^ gmul(o[4*c+1], 3) ^ o[4*c+2] ^ o[4*c+3];
                    s[4*c+1] = o[4*c] ^ gmul(o[4*c+1], 2) ^ gmul(o[4*c+2], 3) ^ o[4*c+3];
                    s[4*c+2] = o[4*c] ^ o[4*c+1] ^ gmul(o[4*c+2], 2) ^ gmul(o[4*c+3], 3);
                    s[4*c+3] = gmul(o[4*c], 3) ^ o[4*c+1] ^ o[4*c+2] ^ gmul(o[4*c+3], 2);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = o[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_tab[rnd][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    // Scoreboard
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] c, input logic [127:0] p);
        int w;
        w = 0;
        in_valid = 1'b1;
        ct = c;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        tick();
        in_valid = 1'b0;
        exp_q.push_back(p);
    endtask

    task automatic wait_out(input bit check_rk);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            if (check_rk && n <= 9) chk("rk_idx_seq", rk_idx, 128'(9 - n));
            tick();
            n++;
        end
        chk("latency", 128'(n), 128'd10);
        if (exp_q.size() > 0) last_exp = exp_q.pop_front();
        else last_exp = '1;
        chk("pt", pt, last_exp);
        chk("in_ready_in_done", in_ready, 0);
    endtask

    task automatic release_out(input int delay);
        out_ready = 1'b0;
        for (int d = 0; d < delay; d++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_pt", pt, last_exp);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_after_handshake", out_valid, 0);
    endtask

    // Stimulus
    initial begin
        int acc_cnt;
        int out_cnt;
        int acc_t[2];
        bit seen;
        logic [127:0] zero_ct;

        rst_n = 1'b0;
        in_valid = 1'b0;
        ct = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        build_tables();

        chk("key_expansion_rk10", rk_tab[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("model_c1_encrypt", encrypt(C1_PT), C1_CT);
        zero_ct = encrypt(128'h0);

        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pt", pt, 0);
        chk("rst_rk_idx", rk_idx, 10);
        #20 rst_n = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_rk_idx", rk_idx, 10);

        // Table-driven vectors: C.1, all-zero plaintext, random plaintexts
        vecs[0] = '{ct: C1_CT, pt: C1_PT};
        vecs[1] = '{ct: zero_ct, pt: 128'h0};
        for (int i = 2; i < 6; i++) begin
            vecs[i].pt = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].ct = encrypt(vecs[i].pt);
        end
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].ct, vecs[i].pt);
            wait_out(1'b1);
            release_out($urandom_range(0, 3));
        end

        // Backpressure with a competing input request
        send(C1_CT, C1_PT);
        wait_out(1'b0);
        in_valid = 1'b1;
        ct = zero_ct;
        for (int d = 0; d < 5; d++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_pt", pt, C1_PT);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_not_accepted_in_done", rk_idx, 10);
        chk("bp_ready_after_handshake", in_ready, 1);
        send(zero_ct, 128'h0);
        wait_out(1'b1);
        release_out(0);

        // Back-to-back with valid and ready held high
        acc_cnt = 0;
        out_cnt = 0;
        acc_t[0] = 0;
        acc_t[1] = 0;
        in_valid = 1'b1;
        ct = C1_CT;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && out_cnt < 2; cyc++) begin
            if (in_valid && in_ready && acc_cnt < 2) begin
                acc_t[acc_cnt] = cyc;
                exp_q.push_back(acc_cnt == 0 ? C1_PT : 128'h0);
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                last_exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                chk("b2b_pt", pt, last_exp);
                out_cnt++;
            end
            tick();
            if (acc_cnt == 1) ct = zero_ct;
            if (acc_cnt == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_accepts", 128'(acc_cnt), 2);
        chk("b2b_outputs", 128'(out_cnt), 2);
        chk("b2b_spacing", 128'(acc_t[1] - acc_t[0]), 12);
        exp_q.delete();
        tick();

        // Flush at round 5
        send(C1_CT, C1_PT);
        repeat (4) tick();
        chk("flush_at_round5", rk_idx, 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle_ready", in_ready, 1);
        chk("flush_rk_idx", rk_idx, 10);
        seen = 1'b0;
        for (int d = 0; d < 15; d++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("flush_no_output", seen, 0);
        exp_q.delete();

        // Flush coincident with a request in IDLE does not accept
        in_valid = 1'b1;
        ct = C1_CT;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_blocks_accept", rk_idx, 10);
        send(C1_CT, C1_PT);
        wait_out(1'b1);
        release_out(1);

        // Asynchronous reset mid-round
        send(zero_ct, 128'h0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_pt", pt, 0);
        chk("mid_rst_rk_idx", rk_idx, 10);
        exp_q.delete();
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int d = 0; d < 15; d++) begin
            if (out_valid || pt !== 128'h0) seen = 1'b1;
            tick();
        end
        chk("post_rst_no_stale", seen, 0);

        // Report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
